// File: rtl/matrix_result_writer.sv
// Streams the result RAM out as 64-byte host line writes, then writes a completion flag line
// and waits until every line write has been acknowledged.
module matrix_result_writer #(
    parameter int Z_DEPTH = 64,
    localparam int AW = $clog2(Z_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [41:0]   base_addr,
    output logic [AW-1:0] z_rd_addr,
    input  logic [31:0]   z_dout,
    output logic          wr_valid,
    output logic [41:0]   wr_addr,
    output logic [511:0]  wr_data,
    input  logic          wr_almfull,
    input  logic          wr_ack,
    output logic          busy,
    output logic          done
);

    localparam int NUM_LINES = Z_DEPTH / 16;
    localparam int LW        = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int AKW       = $clog2(NUM_LINES + 2);
    localparam logic [AKW-1:0] ACK_TARGET = AKW'(NUM_LINES + 1);
    localparam logic [LW-1:0]  LAST_LINE  = LW'(NUM_LINES - 1);
    localparam logic [511:0]   FLAG_LINE  = {416'b0, 32'(NUM_LINES), 64'd1};

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        FLAG,
        WAIT_ACK
    } state_t;

    state_t         state_q, state_d;
    logic [41:0]    base_q, base_d;
    logic [LW-1:0]  line_idx_q, line_idx_d;
    logic [4:0]     word_cnt_q, word_cnt_d;
    logic [AKW-1:0] ack_cnt_q, ack_cnt_d;
    logic [AW-1:0]  z_rd_addr_q, z_rd_addr_d;
    logic [511:0]   line_buf_q, line_buf_d;
    logic           wr_valid_q, wr_valid_d;
    logic [41:0]    wr_addr_q, wr_addr_d;
    logic [511:0]   wr_data_q, wr_data_d;
    logic           done_q, done_d;

    logic           can_issue;
    logic [3:0]     word_sel;
    logic [LW-1:0]  next_line;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        line_idx_d  = line_idx_q;
        word_cnt_d  = word_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        z_rd_addr_d = z_rd_addr_q;
        line_buf_d  = line_buf_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;

        // A request is never issued in the cycle right after another one.
        can_issue = !wr_almfull && !wr_valid_q;
        word_sel  = word_cnt_q[3:0] - 4'd1;
        next_line = line_idx_q + LW'(1);

        if (state_q != IDLE && wr_ack && ack_cnt_q < ACK_TARGET) begin
            ack_cnt_d = ack_cnt_q + AKW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    line_idx_d  = '0;
                    word_cnt_d  = '0;
                    ack_cnt_d   = '0;
                    z_rd_addr_d = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // Read data trails its address by one cycle, so word k lands in count k+1.
                if (word_cnt_q != 5'd0) begin
                    line_buf_d[{word_sel, 5'b00000} +: 32] = z_dout;
                end
                if (word_cnt_q < 5'd15) begin
                    z_rd_addr_d = z_rd_addr_q + AW'(1);
                end
                if (word_cnt_q == 5'd16) begin
                    word_cnt_d = '0;
                    state_d    = WRITE;
                end else begin
                    word_cnt_d = word_cnt_q + 5'd1;
                end
            end
            WRITE: begin
                if (can_issue) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = base_q + 42'd1 + 42'(line_idx_q);
                    wr_data_d  = line_buf_q;
                    line_idx_d = next_line;
                    if (line_idx_q == LAST_LINE) begin
                        state_d = FLAG;
                    end else begin
                        z_rd_addr_d = AW'({next_line, 4'b0000});
                        state_d     = FILL;
                    end
                end
            end
            FLAG: begin
                if (can_issue) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = base_q;
                    wr_data_d  = FLAG_LINE;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_cnt_d >= ACK_TARGET) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            line_idx_q  <= '0;
            word_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            z_rd_addr_q <= '0;
            line_buf_q  <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            line_idx_q  <= line_idx_d;
            word_cnt_q  <= word_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            z_rd_addr_q <= z_rd_addr_d;
            line_buf_q  <= line_buf_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
        end
    end

    assign z_rd_addr = z_rd_addr_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_result_writer.sv
// Scoreboard bench for matrix_result_writer: directed runs push expected line writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_matrix_result_writer;

    localparam int Z_DEPTH   = 64;
    localparam int NUM_LINES = Z_DEPTH / 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [41:0]  base_addr;
    logic [5:0]   z_rd_addr;
    logic [31:0]  z_dout = '0;
    logic         wr_valid;
    logic [41:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_almfull;
    logic         wr_ack = 1'b0;
    logic         busy;
    logic         done;

    matrix_result_writer #(.Z_DEPTH(Z_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .z_rd_addr  (z_rd_addr),
        .z_dout     (z_dout),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_almfull (wr_almfull),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [41:0]  addr;
        logic [511:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_valid_cycle = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] ram_base = '0;
    int          ack_delay = 3;
    logic [7:0]  hist = '0;
    logic [5:0]  addr_neg = '0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    endtask

    // RAM returns the word for the address held in the previous cycle; acks trail writes by ack_delay.
    always @(negedge clk) addr_neg = z_rd_addr;

    always @(posedge clk) begin
        #1;
        z_dout = ram_base + 32'(addr_neg);
        hist   = reset ? 8'h00 : {hist[6:0], wr_valid};
        wr_ack = hist[ack_delay];
    end

    always @(negedge clk) begin
        if (wr_valid) begin
            checkOutput("no_back_to_back", 512'(prev_valid), '0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 512'(wr_addr), '1);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("wr_addr", 512'(wr_addr), 512'(mon_e.addr));
                checkOutput("wr_data", wr_data, mon_e.data);
            end
            last_valid_cycle = cyc;
        end
        prev_valid = wr_valid;
    end

    task automatic applyStimulus(input logic [41:0] base, input logic [31:0] pattern, input int delay);
        wr_t          e;
        logic [511:0] line;
        ram_base  = pattern;
        ack_delay = delay;
        for (int l = 0; l < NUM_LINES; l++) begin
            line = '0;
            for (int k = 0; k < 16; k++) line[32*k +: 32] = pattern + 32'(l * 16 + k);
            e.addr = base + 42'(1 + l);
            e.data = line;
            exp_q.push_back(e);
        end
        e.addr = base;
        e.data = {416'b0, 32'd4, 64'd1};
        exp_q.push_back(e);
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_done_seen"}, 512'(seen), 512'(1));
        if (seen) begin
            checkOutput({name, "_done_timing"}, 512'(cyc), 512'(last_valid_cycle + ack_delay + 1));
            checkOutput({name, "_all_writes"}, 512'(exp_q.size()), '0);
            checkOutput({name, "_idle_at_done"}, 512'(busy), '0);
            @(negedge clk);
            checkOutput({name, "_done_single"}, 512'(done), '0);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_wr_valid"}, 512'(wr_valid), '0);
        checkOutput({name, "_done"}, 512'(done), '0);
        checkOutput({name, "_busy"}, 512'(busy), '0);
        checkOutput({name, "_z_rd_addr"}, 512'(z_rd_addr), '0);
        checkOutput({name, "_wr_addr"}, 512'(wr_addr), '0);
        checkOutput({name, "_wr_data"}, wr_data, '0);
    endtask

    initial begin
        int seen;
        int count;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        wr_almfull = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Nominal four-line run with acks three cycles behind each write.
        applyStimulus(42'h100, 32'h0000_1000, 3);
        waitDone("basic");

        // Back-pressure on line 2: raise almfull during its fill, keep it past 20 WRITE cycles.
        applyStimulus(42'h200, 32'hA500_0000, 3);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wr_valid) seen++;
            if (seen == 2) break;
        end
        checkOutput("stall_reach_line1", 512'(seen), 512'(2));
        wr_almfull = 1'b1;
        count = 0;
        repeat (37) begin
            @(negedge clk);
            if (wr_valid) count++;
        end
        checkOutput("stall_no_valid", 512'(count), '0);
        wr_almfull = 1'b0;
        @(negedge clk);
        checkOutput("stall_release_valid", 512'(wr_valid), 512'(1));
        waitDone("stall");

        // Line addresses wrap past the top of the 42-bit space.
        applyStimulus(42'h3FF_FFFF_FFFE, 32'h5A5A_0000, 3);
        waitDone("wrap");

        // Acks coincide with writes; a stray start mid-fill must not disturb the run.
        applyStimulus(42'h0AB_CDEF_0000, 32'h00C0_FF00, 0);
        repeat (6) @(negedge clk);
        base_addr = 42'h999;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        waitDone("ack_same_cycle");

        // Reset while line 1 is filling aborts the run; a fresh start then completes.
        applyStimulus(42'h300, 32'h7700_0000, 3);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wr_valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput("abort_first_write", 512'(seen), 512'(1));
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetOutputs("abort");
        reset = 1'b0;
        exp_q.delete();
        count = 0;
        repeat (60) begin
            @(negedge clk);
            if (wr_valid || done) count++;
        end
        checkOutput("abort_quiet", 512'(count), '0);
        applyStimulus(42'h400, 32'h1234_0000, 3);
        waitDone("after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_result_writer.md
MATRIX_RESULT_WRITER -- requirements
Module: matrix_result_writer

Interface
REQ-001 Parameter Z_DEPTH, default 64, SHALL set the number of 32-bit result words; legal value is any positive multiple of 16.
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high.
REQ-004 start  input  1  SHALL be a one-cycle pulse requesting writeback; it is honoured only in IDLE.
REQ-005 base_addr  input  42  SHALL be the cache-line address of the flag line, sampled when start is honoured.
REQ-006 z_rd_addr  output  log2(Z_DEPTH)  SHALL be the read address into the result RAM.
REQ-007 z_dout  input  32  SHALL be the RAM read data, valid exactly one cycle after z_rd_addr.
REQ-008 wr_valid  output  1  SHALL mark a one-cycle host line-write request.
REQ-009 wr_addr  output  42  SHALL be the cache-line address of the write.
REQ-010 wr_data  output  512  SHALL be the line payload.
REQ-011 wr_almfull  input  1  SHALL indicate the write channel cannot accept a new request.
REQ-012 wr_ack  input  1  SHALL pulse once per completed line write.
REQ-013 busy  output  1  SHALL be high in every state other than IDLE.
REQ-014 done  output  1  SHALL pulse for one cycle when all writes have been acknowledged.

Function
REQ-015 The FSM SHALL have states IDLE, FILL, WRITE, FLAG and WAIT_ACK.
REQ-016 IDLE -> FILL on start: latch base_addr, clear line_idx, word counter and ack counter.
REQ-017 FILL SHALL issue 16 consecutive z_rd_addr values, one per cycle, from line_idx*16.
REQ-018 Each z_dout SHALL be captured one cycle after its address, with word k of the line in wr_data bits [32k+31:32k].
REQ-019 FILL -> WRITE SHALL occur the cycle after the 16th word is captured, so a FILL lasts 17 cycles.
REQ-020 In WRITE with wr_almfull low, the next cycle SHALL present wr_valid=1, wr_addr=base+1+line_idx (mod 2^42) and the packed line.
REQ-021 After that write, line_idx SHALL increment; the FSM goes to FLAG if the last line (Z_DEPTH/16-1) was written, else to FILL.
REQ-022 In WRITE or FLAG with wr_almfull high, the FSM SHALL hold and wr_valid SHALL stay 0; the line buffer is unchanged.
REQ-023 In FLAG with wr_almfull low, the next cycle SHALL present wr_valid=1, wr_addr=base_addr and wr_data with [63:0]=64'h1, [95:64]=Z_DEPTH/16 and all other bits 0; the FSM then goes to WAIT_ACK.
REQ-024 wr_valid SHALL never be high on two consecutive cycles.
REQ-025 wr_valid SHALL be 0 whenever no request is issued; wr_addr and wr_data may hold stale values.
REQ-026 The ack counter SHALL count every wr_ack in every non-IDLE state, including a wr_ack coincident with wr_valid.
REQ-027 In WAIT_ACK, when the ack count reaches Z_DEPTH/16+1, done SHALL pulse for one cycle and the FSM SHALL return to IDLE in the same cycle.
REQ-028 wr_ack in IDLE SHALL be ignored.
REQ-029 start while busy SHALL be ignored with no effect on base_addr or progress.
REQ-030 z_rd_addr SHALL hold its last value outside FILL.

Reset
REQ-031 On reset: state=IDLE; wr_valid=0, done=0, busy=0, z_rd_addr=0, wr_addr=0, wr_data=0; all counters cleared.
REQ-032 Reset asserted mid-operation SHALL abort without issuing any further write or done; the following start runs a full sequence.

Verification
REQ-033 RAM word i = 32'h1000+i, base_addr=42'h100, wr_almfull=0, each ack 3 cycles after its write -> 4 writes at 0x101..0x104 with line0 word0=0x1000 and word15=0x100F, then the flag at 0x100 with [63:0]=1 and [95:64]=4, then one done pulse.
REQ-034 Hold wr_almfull=1 for 20 cycles on entry to WRITE for line 2 -> no wr_valid during the stall; the write issues 1 cycle after release with correct data.
REQ-035 base_addr=42'h3FF_FFFF_FFFE -> data lines written to 0x3FF_FFFF_FFFF, 0x0, 0x1, 0x2.
REQ-036 Assert wr_ack in the same cycle as each wr_valid, and pulse start mid-FILL -> the start is ignored and done occurs the cycle the 5th ack is counted.
REQ-037 Assert reset during line 1's FILL -> outputs return to reset values next cycle with no further writes; a new start completes normally.
